ctc_int_ctrl: RTL and testbench
===============================

Name: ctc_int_ctrl

Overview:
- Interrupt controller for the N-channel counter/timer block.
- Collects per-channel zero-count interrupt requests and arbitrates them by fixed priority.
- Drives the Z80 mode-2 interrupt handshake: int_n, vector on acknowledge, and IEI/IEO daisy chain.
- Tracks in-service channels and retires them on a snooped RETI (ED 4D) opcode fetch.

Parameters:
- CHAN, 4, number of counter/timer channels (2..8).
- AWID, 2, channel index width, clog2(CHAN).
- DWID, 8, data bus width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous active-low reset.
- m1_n  input  1  Z80 M1, active low.
- iorq_n  input  1  Z80 IORQ, active low.
- rd_n  input  1  Z80 RD, active low.
- din  input  DWID  CPU data bus, snooped for opcodes.
- dout  output  DWID  vector output during acknowledge.
- oe_n  output  1  dout drive enable, active low.
- iei  input  1  daisy-chain enable in.
- ieo  output  1  daisy-chain enable out.
- int_n  output  1  interrupt request to CPU, active low.
- vec_base  input  DWID  vector register from the channel block.
- int_en  input  CHAN  per-channel interrupt enable (control word bit 7).
- int_req  input  CHAN  one-cycle zero-count pulse per channel.
- in_service  output  CHAN  in-service status, for debug and verification.

Behaviour:
- Single clock domain.
- Reset: synchronous, active-low, sampled on the clk rising edge. It clears pending, in_service and the RETI FSM. Output values during reset:
  - int_n=1, oe_n=1, dout=0.
  - ieo follows iei, since nothing is pending or in service.
- Reset asserted mid-acknowledge drops oe_n and int_n to 1 on the next edge.
- Pending:
  - pending[i] sets on int_req[i]&int_en[i].
  - pending[i] clears on acknowledge of channel i, or when int_en[i]=0.
  - A new int_req[i] in the same cycle as its acknowledge sets pending[i] again: set wins.
- Eligibility: channel i is eligible when pending[i]=1 and in_service[j]=0 for all j<=i. Channel 0 has the highest priority. winner = lowest eligible index.
- int_n is registered: int_n <= ~(iei & any eligible).
  - Latency: int_req at edge N -> pending at N+1 -> int_n=0 after edge N+2.
  - iei=0 deasserts int_n on the next edge.
- ieo is combinational: ieo = iei & ~|in_service & ~|pending. It is glitch-free w.r.t. internal state, which is registered.
- Acknowledge detect:
  - ack1 = ~m1_n & ~iorq_n.
  - ack_stb = ack1 & ~ack1_q (one clock).
  - On ack_stb with iei=1 and int_n=0:
    - latch winner w;
    - set in_service[w];
    - clear pending[w];
    - dout <= vector, where vector = vec_base with bit0=0 and bits [AWID:1]=w (upper bits from vec_base);
    - oe_n <= 0.
  - oe_n and dout hold while ack1=1; one cycle after ack1 falls, oe_n=1 and dout=0.
  - ack_stb when not requesting (iei=0 or int_n=1): no state change, oe_n stays 1.
- RETI FSM (states IDLE, SAW_ED):
  - fetch1 = ~m1_n & ~rd_n & iorq_n; fetch_stb = rising edge of fetch1.
  - IDLE: fetch_stb with din=8'hED -> SAW_ED.
  - SAW_ED, on fetch_stb:
    - din=8'h4D and iei=1 -> clear the lowest-index set in_service bit, then IDLE;
    - din=8'h4D and iei=0 -> IDLE with no clear (a higher-priority device owns it);
    - din=8'hED -> stay in SAW_ED;
    - any other value -> IDLE.
  - Non-fetch cycles do not change the FSM.
- Nesting: a higher-priority channel may interrupt while a lower one is in service. Multiple in_service bits may be set; each RETI clears only the highest-priority one.
- int_en[i]=0 clears pending[i] but never in_service[i].

Test Plan:
- Reset with iei=1, no requests -> int_n=1, oe_n=1, dout=0, ieo=1. Pulse int_req=4'b0100, int_en=4'hF -> int_n=0 two cycles later, ieo=0.
- vec_base=8'hA0, pending channels 1 and 2, ack cycle -> dout=8'hA2 with oe_n=0. Then in_service=4'b0010, int_n stays 1 because channel 2 is blocked by in-service channel 1.
- Fetch ED then 4D with iei=1 -> in_service=0. Next ack -> dout=8'hA4, in_service=4'b0100.
- Sequences ED,00,4D and ED,ED,4D -> no clear, then clear. Sequence ED,4D with iei=0 -> in_service unchanged.
- Channel 3 in service, int_req[0] -> int_n=0; ack gives dout=vec_base|8'h00, in_service=4'b1001. RETI clears bit 0 only.
- int_req[1] then int_en[1]=0 before ack -> pending cleared, int_n=1. reset_n=0 during ack -> oe_n=1 and int_n=1 on the next edge.

Source files
------------

// File: rtl/ctc_int_ctrl.sv
// Z80 mode-2 interrupt controller for the counter/timer channels: fixed-priority
// arbitration, IEI/IEO daisy chain, vector on acknowledge, RETI snooping.
module ctc_int_ctrl #(
  parameter int CHAN = 4,
  parameter int AWID = 2,
  parameter int DWID = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            m1_n,
  input  logic            iorq_n,
  input  logic            rd_n,
  input  logic [DWID-1:0] din,
  output logic [DWID-1:0] dout,
  output logic            oe_n,
  input  logic            iei,
  output logic            ieo,
  output logic            int_n,
  input  logic [DWID-1:0] vec_base,
  input  logic [CHAN-1:0] int_en,
  input  logic [CHAN-1:0] int_req,
  output logic [CHAN-1:0] in_service
);

  // state  | meaning
  // IDLE   | waiting for an ED opcode fetch
  // SAW_ED | ED fetched; a following 4D fetch is a RETI
  typedef enum logic {IDLE = 1'b0, SAW_ED = 1'b1} reti_t;

  reti_t           state_q, state_d;
  logic [CHAN-1:0] pending_q, pending_d;
  logic [CHAN-1:0] in_service_q, in_service_d;
  logic            int_n_q, int_n_d;
  logic            oe_n_q, oe_n_d;
  logic [DWID-1:0] dout_q, dout_d;
  logic            ack1_q, ack1_d;
  logic            fetch1_q, fetch1_d;

  logic [CHAN-1:0] elig;
  logic [AWID-1:0] winner;
  logic            any_elig;
  logic            blocked;
  logic [DWID-1:0] vec;
  logic [CHAN-1:0] win_mask;
  logic            ack_stb, ack_ok, fetch_stb, reti_clr;

  // A channel is blocked by its own or any higher-priority in-service bit.
  always_comb begin
    blocked = 1'b0;
    elig    = '0;
    for (int i = 0; i < CHAN; i++) begin
      blocked = blocked | in_service_q[i];
      elig[i] = pending_q[i] & ~blocked;
    end
    winner = '0;
    for (int i = CHAN - 1; i >= 0; i--) begin
      if (elig[i]) winner = AWID'(i);
    end
    any_elig = |elig;
    win_mask = CHAN'(1) << winner;
    vec          = vec_base;
    vec[AWID:1]  = winner;
    vec[0]       = 1'b0;
  end

  always_comb begin
    ack1_d    = ~m1_n & ~iorq_n;
    fetch1_d  = ~m1_n & ~rd_n & iorq_n;
    ack_stb   = ack1_d & ~ack1_q;
    fetch_stb = fetch1_d & ~fetch1_q;
    // any_elig guards against int_en dropping in the very cycle of the acknowledge
    ack_ok    = ack_stb & iei & ~int_n_q & any_elig;

    state_d  = state_q;
    reti_clr = 1'b0;
    if (fetch_stb) begin
      case (state_q)
        IDLE:   if (din == 8'hED) state_d = SAW_ED;
        SAW_ED: begin
          if (din == 8'hED) begin
            state_d = SAW_ED;
          end else begin
            state_d  = IDLE;
            reti_clr = (din == 8'h4D) & iei;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    pending_d = pending_q;
    if (ack_ok) pending_d = pending_d & ~win_mask;
    pending_d = (pending_d | int_req) & int_en;

    in_service_d = in_service_q;
    if (reti_clr) in_service_d = in_service_d & (in_service_d - CHAN'(1));
    if (ack_ok)   in_service_d = in_service_d | win_mask;

    int_n_d = ~(iei & any_elig & ~ack_ok);

    if (ack_ok) begin
      oe_n_d = 1'b0;
      dout_d = vec;
    end else if (ack1_d && !oe_n_q) begin
      oe_n_d = oe_n_q;
      dout_d = dout_q;
    end else begin
      oe_n_d = 1'b1;
      dout_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      in_service_q <= '0;
      int_n_q      <= 1'b1;
      oe_n_q       <= 1'b1;
      dout_q       <= '0;
      ack1_q       <= 1'b0;
      fetch1_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      int_n_q      <= int_n_d;
      oe_n_q       <= oe_n_d;
      dout_q       <= dout_d;
      ack1_q       <= ack1_d;
      fetch1_q     <= fetch1_d;
    end
  end

  assign ieo        = iei & ~|in_service_q & ~|pending_q;
  assign int_n      = int_n_q;
  assign oe_n       = oe_n_q;
  assign dout       = dout_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_ctc_int_ctrl.sv
// Directed bench for ctc_int_ctrl: request latency, vectoring, nesting,
// RETI decoding, enable clearing and reset during acknowledge.
module tb_ctc_int_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, m1_n, iorq_n, rd_n, iei, ieo, int_n, oe_n;
  logic [7:0] din, dout, vec_base;
  logic [3:0] int_en, int_req, in_service;
  int checks = 0;
  int errors = 0;

  ctc_int_ctrl #(.CHAN(4), .AWID(2), .DWID(8)) dut (
    .clk(clk), .reset_n(reset_n), .m1_n(m1_n), .iorq_n(iorq_n), .rd_n(rd_n),
    .din(din), .dout(dout), .oe_n(oe_n), .iei(iei), .ieo(ieo), .int_n(int_n),
    .vec_base(vec_base), .int_en(int_en), .int_req(int_req), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [7:0] b);
    m1_n = 1'b0; rd_n = 1'b0; din = b;
    tick();
    m1_n = 1'b1; rd_n = 1'b1; din = 8'h00;
    tick();
  endtask

  task automatic ack_on();
    m1_n = 1'b0; iorq_n = 1'b0;
    tick();
  endtask

  task automatic ack_off();
    m1_n = 1'b1; iorq_n = 1'b1;
    tick();
  endtask

  task automatic pulse_req(input logic [3:0] r);
    int_req = r;
    tick();
    int_req = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0; m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; din = 8'h00;
    iei = 1'b1; vec_base = 8'hA0; int_en = 4'hF; int_req = 4'h0;
    tick(); tick();
    chk("rst_int_n", int_n, 1);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_dout", dout, 0);
    chk("rst_ieo", ieo, 1);
    reset_n = 1'b1;
    tick();

    // request latency: pending after one edge, int_n low after the second
    pulse_req(4'b0100);
    chk("lat_int_n_1", int_n, 1);
    chk("lat_ieo", ieo, 0);
    tick();
    chk("lat_int_n_2", int_n, 0);

    // channels 1 and 2 pending, channel 1 wins
    pulse_req(4'b0010);
    ack_on();
    chk("ack1_dout", dout, 8'hA2);
    chk("ack1_oe_n", oe_n, 0);
    chk("ack1_insvc", in_service, 4'b0010);
    tick();
    chk("ack1_hold_dout", dout, 8'hA2);
    chk("ack1_blocked_int_n", int_n, 1);
    ack_off();
    chk("ack1_rel_oe_n", oe_n, 1);
    chk("ack1_rel_dout", dout, 0);

    // RETI retires channel 1, channel 2 then requests and is vectored
    fetch(8'hED); fetch(8'h4D);
    chk("reti1_insvc", in_service, 4'b0000);
    chk("reti1_int_n", int_n, 0);
    ack_on();
    chk("ack2_dout", dout, 8'hA4);
    chk("ack2_insvc", in_service, 4'b0100);
    ack_off();

    fetch(8'hED); fetch(8'h00); fetch(8'h4D);
    chk("ed00_insvc", in_service, 4'b0100);
    fetch(8'hED); fetch(8'hED); fetch(8'h4D);
    chk("eded4d_insvc", in_service, 4'b0000);
    chk("eded4d_ieo", ieo, 1);

    // RETI seen while iei=0 belongs to an upstream device
    pulse_req(4'b0100); tick(); tick();
    ack_on(); ack_off();
    chk("svc2_insvc", in_service, 4'b0100);
    iei = 1'b0;
    fetch(8'hED); fetch(8'h4D);
    chk("iei0_insvc", in_service, 4'b0100);
    chk("iei0_ieo", ieo, 0);
    iei = 1'b1;
    fetch(8'hED); fetch(8'h4D);
    chk("iei1_insvc", in_service, 4'b0000);

    // nesting: channel 0 interrupts channel 3
    pulse_req(4'b1000); tick(); tick();
    ack_on();
    chk("ch3_dout", dout, 8'hA6);
    ack_off();
    pulse_req(4'b0001); tick();
    chk("nest_int_n", int_n, 0);
    ack_on();
    chk("nest_dout", dout, 8'hA0);
    chk("nest_insvc", in_service, 4'b1001);
    ack_off();
    fetch(8'hED); fetch(8'h4D);
    chk("nest_reti_insvc", in_service, 4'b1000);
    fetch(8'hED); fetch(8'h4D);
    chk("nest_reti2_insvc", in_service, 4'b0000);

    // disabling a pending channel withdraws the request
    pulse_req(4'b0010);
    int_en = 4'b1101;
    tick(); tick();
    chk("dis_int_n", int_n, 1);
    chk("dis_ieo", ieo, 1);
    int_en = 4'hF;

    // iei low blocks int_n on the next edge
    pulse_req(4'b0001); tick();
    chk("iei_req_int_n", int_n, 0);
    iei = 1'b0;
    tick();
    chk("iei_drop_int_n", int_n, 1);
    iei = 1'b1;
    tick();
    chk("iei_back_int_n", int_n, 0);

    // new request in the acknowledge cycle keeps the channel pending
    m1_n = 1'b0; iorq_n = 1'b0; int_req = 4'b0001;
    tick();
    int_req = 4'h0;
    chk("setwin_insvc", in_service, 4'b0001);
    ack_off();
    fetch(8'hED); fetch(8'h4D);
    chk("setwin_int_n", int_n, 0);

    // reset in the middle of an acknowledge
    ack_on();
    chk("rstack_oe_n_pre", oe_n, 0);
    reset_n = 1'b0;
    tick();
    chk("rstack_oe_n", oe_n, 1);
    chk("rstack_int_n", int_n, 1);
    chk("rstack_insvc", in_service, 4'b0000);
    reset_n = 1'b1;
    ack_off();

    // acknowledge with nothing requested changes nothing
    ack_on();
    chk("idle_ack_oe_n", oe_n, 1);
    chk("idle_ack_insvc", in_service, 4'b0000);
    ack_off();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
